x_micro_seq_engine: RTL and testbench

Parametrised micro-sequencer: a writable program RAM of DEPTH words (CMD_W opcode + DATA_W payload) executed from address 0 on a start pulse. It supports output, timed wait, jump, a counted loop and halt, with busy/done status and an abort. It replaces the fixed-width, non-executing sequencer shell as the control source for the delay-line test fixtures.

---
 rtl/x_micro_seq_pkg.sv | 26 ++
 rtl/x_micro_seq_ram.sv | 25 ++
 rtl/x_micro_seq_engine.sv | 131 +++++++++++++
 tb/tb_x_micro_seq_engine.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/x_micro_seq_pkg.sv
// Shared types for the micro-sequencer: opcode and FSM state encodings.
// The TRIG state/opcode are only reachable when X_MICRO_SEQ_TRIG_EN is defined.
package x_micro_seq_pkg;

  localparam int unsigned OPC_W = 3;

  typedef enum logic [OPC_W-1:0] {
    OP_NOP   = 3'd0,
    OP_OUT   = 3'd1,
    OP_WAIT  = 3'd2,
    OP_JMP   = 3'd3,
    OP_LDC   = 3'd4,
    OP_DJNZ  = 3'd5,
    OP_HALT  = 3'd6,
    OP_WTRIG = 3'd7
  } opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_EXEC,
    ST_WAIT,
    ST_TRIG
  } state_e;

endpackage

// File: rtl/x_micro_seq_ram.sv
// Program store: simple dual-port RAM, one write port, one registered read port.
// No reset on the array so program contents survive a reset.
module x_micro_seq_ram #(
  parameter int unsigned WIDTH = 40,
  parameter int unsigned AW    = 9
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/x_micro_seq_engine.sv
// Micro-sequencer engine: fetch/execute FSM, pc, wait and loop counters, OUT register.
// Define X_MICRO_SEQ_TRIG_EN to add the i_trig port and the WTRIG/TRIG wait.
module x_micro_seq_engine
  import x_micro_seq_pkg::*;
#(
  parameter int unsigned DATA_W = 36,
  parameter int unsigned CMD_W  = 4,
  parameter int unsigned AW     = 9,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_stop,
  output logic              o_busy,
  output logic              o_done,
  input  logic              i_wen,
  input  logic [CMD_W-1:0]  i_wcmd,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [AW-1:0]     i_waddr,
  output logic [DATA_W-1:0] o_data,
  output logic [AW-1:0]     o_pc
`ifdef X_MICRO_SEQ_TRIG_EN
  ,input logic              i_trig
`endif
);

  state_e                    state;
  logic [AW-1:0]             pc;
  logic [CNT_W-1:0]          loop_cnt;
  logic [CNT_W-1:0]          wait_cnt;
  logic [CNT_W-1:0]          loop_dec;
  logic [CMD_W+DATA_W-1:0]   rd_word;
  logic [CMD_W-1:0]          cmd;
  logic [DATA_W-1:0]         payload;
  opcode_e                   op;

  x_micro_seq_ram #(
    .WIDTH (CMD_W + DATA_W),
    .AW    (AW)
  ) u_ram (
    .clk   (i_clk),
    .we    (i_wen & ~o_busy),
    .waddr (i_waddr),
    .wdata ({i_wcmd, i_wdata}),
    .raddr (pc),
    .rdata (rd_word)
  );

  assign cmd      = rd_word[CMD_W+DATA_W-1:DATA_W];
  assign payload  = rd_word[DATA_W-1:0];
  assign loop_dec = loop_cnt - CNT_W'(1);
  assign o_pc     = pc;

  // Any opcode with bits set above the 3-bit field decodes as NOP.
  always_comb begin
    op = OP_NOP;
    if ((cmd >> OPC_W) == '0) op = opcode_e'(cmd[OPC_W-1:0]);
`ifndef X_MICRO_SEQ_TRIG_EN
    if (op == OP_WTRIG) op = OP_NOP;
`endif
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state    <= ST_IDLE;
      pc       <= '0;
      loop_cnt <= '0;
      wait_cnt <= '0;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
      o_data   <= '0;
    end else begin
      o_done <= 1'b0;
      if (i_stop) begin
        state  <= ST_IDLE;
        o_busy <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (i_start) begin
              state  <= ST_FETCH;
              pc     <= '0;
              o_busy <= 1'b1;
            end
          end
          ST_FETCH: state <= ST_EXEC;
          ST_EXEC: begin
            pc    <= pc + AW'(1);
            state <= ST_FETCH;
            case (op)
              OP_OUT:  o_data <= payload;
              OP_WAIT: begin
                if (payload[CNT_W-1:0] != '0) begin
                  wait_cnt <= payload[CNT_W-1:0];
                  state    <= ST_WAIT;
                end
              end
              OP_JMP:  pc <= payload[AW-1:0];
              OP_LDC:  loop_cnt <= payload[CNT_W-1:0];
              OP_DJNZ: begin
                loop_cnt <= loop_dec;
                if (loop_dec != '0) pc <= payload[AW-1:0];
              end
              OP_HALT: begin
                state  <= ST_IDLE;
                o_busy <= 1'b0;
                o_done <= 1'b1;
              end
`ifdef X_MICRO_SEQ_TRIG_EN
              OP_WTRIG: state <= ST_TRIG;
`endif
              default: ;
            endcase
          end
          ST_WAIT: begin
            wait_cnt <= wait_cnt - CNT_W'(1);
            if (wait_cnt == CNT_W'(1)) state <= ST_FETCH;
          end
`ifdef X_MICRO_SEQ_TRIG_EN
          ST_TRIG: begin
            if (i_trig) state <= ST_FETCH;
          end
`endif
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_x_micro_seq_engine.sv
// Directed bench for x_micro_seq_engine; o_data changes and o_done pulses are
// matched against a scoreboard of expected (value, cycle-after-start) entries.
module tb_x_micro_seq_engine;

  localparam int unsigned DATA_W = 36;
  localparam int unsigned CMD_W  = 4;
  localparam int unsigned AW     = 9;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned DEPTH  = 1 << AW;

  localparam logic [3:0] C_NOP = 4'd0, C_OUT = 4'd1, C_WAIT = 4'd2, C_JMP = 4'd3,
                         C_LDC = 4'd4, C_DJNZ = 4'd5, C_HALT = 4'd6, C_WTRIG = 4'd7;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic              wen = 1'b0;
  logic              trig = 1'b0;
  logic [CMD_W-1:0]  wcmd = '0;
  logic [DATA_W-1:0] wdata = '0;
  logic [AW-1:0]     waddr = '0;
  logic              busy, done;
  logic [DATA_W-1:0] data;
  logic [AW-1:0]     pc;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;
  int unsigned cyc = 0;
  int unsigned start_cyc = 0;
  bit          mon_en = 1'b0;

  typedef struct {
    logic [DATA_W-1:0] d;
    int unsigned       c;
  } exp_t;

  exp_t              data_q[$];
  int unsigned       done_q[$];
  exp_t              e;
  int unsigned       dc;
  logic [DATA_W-1:0] prev_data = '0;

  x_micro_seq_engine #(
    .DATA_W (DATA_W),
    .CMD_W  (CMD_W),
    .AW     (AW),
    .CNT_W  (CNT_W)
  ) dut (
    .i_clk   (clk),
    .i_rst   (rst_n),
    .i_start (start),
    .i_stop  (stop),
    .o_busy  (busy),
    .o_done  (done),
    .i_wen   (wen),
    .i_wcmd  (wcmd),
    .i_wdata (wdata),
    .i_waddr (waddr),
    .o_data  (data),
    .o_pc    (pc)
`ifdef X_MICRO_SEQ_TRIG_EN
    ,.i_trig (trig)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!mon_en) begin
      prev_data = data;
    end else begin
      if (data !== prev_data) begin
        if (data_q.size() == 0) begin
          chk("unexpected_data", 64'(data), 64'(prev_data));
        end else begin
          e = data_q.pop_front();
          chk("data_val", 64'(data), 64'(e.d));
          chk("data_cyc", 64'(cyc - start_cyc), 64'(e.c));
        end
        prev_data = data;
      end
      if (done === 1'b1) begin
        if (done_q.size() == 0) begin
          chk("unexpected_done", 64'(done), 64'(0));
        end else begin
          dc = done_q.pop_front();
          chk("done_cyc", 64'(cyc - start_cyc), 64'(dc));
        end
      end
    end
  end

  task automatic tick(input int unsigned n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [3:0] c, input logic [DATA_W-1:0] d);
    waddr = a;
    wcmd  = c;
    wdata = d;
    wen   = 1'b1;
    tick();
    wen   = 1'b0;
  endtask

  task automatic go();
    start     = 1'b1;
    start_cyc = cyc;
    tick();
    start     = 1'b0;
  endtask

  task automatic run_to_idle(input string tag, input int unsigned max);
    for (int unsigned i = 0; i < max && busy === 1'b1; i++) tick();
    chk(tag, 64'(busy), 64'(0));
    tick();
  endtask

  task automatic q_empty(input string tag);
    chk({tag, "_dq"}, 64'(data_q.size()), 64'(0));
    chk({tag, "_doneq"}, 64'(done_q.size()), 64'(0));
    data_q.delete();
    done_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    // Reset state
    tick(2);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_data", 64'(data), 64'(0));
    chk("rst_pc", 64'(pc), 64'(0));
    chk("rst_loop", 64'(dut.loop_cnt), 64'(0));
    rst_n = 1'b1;
    tick();
    mon_en = 1'b1;

    // OUT A5, OUT 5A, HALT; HALT written in the same cycle as start
    wr(0, C_OUT, 36'hA5);
    wr(1, C_OUT, 36'h5A);
    data_q.push_back('{36'hA5, 3});
    data_q.push_back('{36'h5A, 5});
    done_q.push_back(7);
    waddr = 2; wcmd = C_HALT; wdata = '0; wen = 1'b1;
    go();
    wen = 1'b0;
    chk("t1_busy1", 64'(busy), 64'(1));
    chk("t1_pc1", 64'(pc), 64'(0));
    tick(5);
    chk("t1_busy6", 64'(busy), 64'(1));
    tick();
    chk("t1_busy7", 64'(busy), 64'(0));
    tick();
    q_empty("t1");

    // WAIT 10 then WAIT 0
    wr(0, C_WAIT, 36'd10);
    wr(1, C_OUT, 36'd1);
    wr(2, C_HALT, 36'd0);
    data_q.push_back('{36'd1, 15});
    done_q.push_back(17);
    go();
    run_to_idle("t2_end", 40);
    q_empty("t2");
    wr(0, C_WAIT, 36'd0);
    wr(1, C_OUT, 36'd2);
    data_q.push_back('{36'd2, 5});
    done_q.push_back(7);
    go();
    run_to_idle("t2b_end", 40);
    q_empty("t2b");

    // Counted loop: three OUT passes
    wr(0, C_LDC, 36'd3);
    wr(1, C_OUT, 36'd7);
    wr(2, C_DJNZ, 36'd1);
    wr(3, C_HALT, 36'd0);
    data_q.push_back('{36'd7, 5});
    done_q.push_back(17);
    go();
    run_to_idle("t3_end", 60);
    chk("t3_loop", 64'(dut.loop_cnt), 64'(0));
    q_empty("t3");

    // DJNZ with loop_cnt = 0 wraps to all-ones and jumps over the OUT
    wr(0, C_DJNZ, 36'd2);
    wr(1, C_OUT, 36'h11);
    wr(2, C_HALT, 36'd0);
    done_q.push_back(5);
    go();
    run_to_idle("t3b_end", 40);
    chk("t3b_loop", 64'(dut.loop_cnt), 64'(16'hFFFF));
    q_empty("t3b");

    // WTRIG, OUT 3, HALT
    wr(0, C_WTRIG, 36'd0);
    wr(1, C_OUT, 36'd3);
    wr(2, C_HALT, 36'd0);
`ifdef X_MICRO_SEQ_TRIG_EN
    data_q.push_back('{36'd3, 26});
    done_q.push_back(28);
    go();
    tick(21);
    chk("t4_busy_trig", 64'(busy), 64'(1));
    chk("t4_pc_trig", 64'(pc), 64'(1));
    tick();
    trig = 1'b1;
    run_to_idle("t4_end", 40);
    trig = 1'b0;
`else
    data_q.push_back('{36'd3, 5});
    done_q.push_back(7);
    go();
    run_to_idle("t4_end", 40);
`endif
    q_empty("t4");

    // JMP-to-self: writes/starts while busy are dropped, stop aborts
    wr(0, C_JMP, 36'd0);
    go();
    tick(4);
    chk("t5_pc", 64'(pc), 64'(0));
    waddr = 0; wcmd = C_OUT; wdata = 36'h99; wen = 1'b1; start = 1'b1;
    tick();
    wen = 1'b0; start = 1'b0;
    tick(3);
    chk("t5_busy_run", 64'(busy), 64'(1));
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("t5_stop", 64'(busy), 64'(0));
    go();
    tick(6);
    chk("t5_restart", 64'(busy), 64'(1));
    stop = 1'b1; start = 1'b1;
    tick();
    chk("t5_stop2", 64'(busy), 64'(0));
    tick();
    stop = 1'b0; start = 1'b0;
    chk("t5_prio", 64'(busy), 64'(0));
    tick(3);
    q_empty("t5");

    // pc wrap DEPTH-1 -> 0; addr 5 holds an out-of-range opcode (NOP)
    wr(0, C_JMP, 36'd1);
    for (int unsigned a = 1; a < DEPTH; a++) begin
      if (a == 5) wr(AW'(a), 4'h9, 36'h77);
      else        wr(AW'(a), C_NOP, 36'd0);
    end
    go();
    for (int unsigned i = 0; i < 3000 && pc !== AW'(DEPTH - 1); i++) tick();
    chk("t6_reach", 64'(pc), 64'(DEPTH - 1));
    tick();
    chk("t6_exec_last", 64'(pc), 64'(DEPTH - 1));
    tick();
    chk("t6_wrap", 64'(pc), 64'(0));
    tick(2);
    chk("t6_jmp", 64'(pc), 64'(1));
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("t6_stop", 64'(busy), 64'(0));
    wr(0, C_HALT, 36'd0);
    done_q.push_back(3);
    go();
    run_to_idle("t6_halt_end", 20);
    chk("t6_halt_pc", 64'(pc), 64'(1));
    q_empty("t6");

    // Reset mid-run, program retained
    wr(0, C_OUT, 36'h3C);
    wr(1, C_JMP, 36'd1);
    data_q.push_back('{36'h3C, 3});
    go();
    tick(5);
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    chk("t7_busy", 64'(busy), 64'(0));
    chk("t7_done", 64'(done), 64'(0));
    chk("t7_data", 64'(data), 64'(0));
    chk("t7_pc", 64'(pc), 64'(0));
    chk("t7_loop", 64'(dut.loop_cnt), 64'(0));
    tick();
    rst_n = 1'b1;
    tick();
    mon_en = 1'b1;
    q_empty("t7a");
    data_q.push_back('{36'h3C, 3});
    go();
    tick(5);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("t7_stop", 64'(busy), 64'(0));
    tick();
    q_empty("t7");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
